// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and constants for the tx and rx sides
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter producing a terminal-count pulse
//  clk     in  system clock
//  rst_n   in  asynchronous active-low reset
//  clear   in  hold the counter at zero
//  bit_end out high on the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  // restarting at the terminal count keeps every bit exactly CLKS_PER_BIT long
  always_comb cnt_d = (clear || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes onto a UART line, optional parity, 1 or 2 stop bits
//  clk      in  system clock
//  rst_n    in  asynchronous active-low reset
//  valid_in in  byte strobe, accepted only in IDLE
//  byte_in  in  byte to send
//  tx_busy  out back-pressure to the upstream buffer
//  tx       out serial line, idles high
//  tx_done  out one-cycle pulse at the end of the last stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [7:0] byte_in,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_done
);
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  uart_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       tx_done_q, tx_done_d;
  logic       bit_end;
  logic       accept;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .bit_end (bit_end)
  );
  assign accept  = state_q == IDLE && valid_in;
  // combinational so the buffer never issues a second byte right after the first
  assign tx_busy = state_q != IDLE || valid_in;
  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = valid_in ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && idx_q == LAST_DATA) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = (bit_end && idx_q == LAST_STOP) ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so tx and tx_done change on the same edge as the FSM
  always_comb begin
    shift_d   = accept ? byte_in : (state_q == DATA && bit_end) ? {1'b0, shift_q[7:1]} : shift_q;
    par_d     = accept ? (^byte_in ^ 1'(PARITY_ODD)) : par_q;
    idx_d     = (state_d != state_q && (state_d == DATA || state_d == STOP)) ? 3'd0 :
                (bit_end && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
    tx_d      = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    tx_done_d = state_q == STOP && state_d == IDLE;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] valid_v = '0;
  logic [7:0] byte_in = '0;
  logic [2:0] tx_v, done_v, busy_v;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  // 0: 8N1, 1: even parity + 2 stop, 2: odd parity + 2 stop
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_v[0]), .byte_in(byte_in),
    .tx_busy(busy_v[0]), .tx(tx_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_v[1]), .byte_in(byte_in),
    .tx_busy(busy_v[1]), .tx(tx_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_v[2]), .byte_in(byte_in),
    .tx_busy(busy_v[2]), .tx(tx_v[2]), .tx_done(done_v[2]));
  // line monitor on dut0: 8N1 receiver sampling mid-bit, plus pulse and protocol counters
  logic       mon_en = 1'b0;
  logic       in_frame = 1'b0;
  int         mcnt = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         proto_err = 0;
  int         stop_err = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         starts[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!mon_en) begin
      in_frame  <= 1'b0;
      mcnt      <= 0;
      done_cnt  <= 0;
      proto_err <= 0;
      stop_err  <= 0;
      rx_q.delete();
      starts.delete();
    end else begin
      if (done_v[0]) done_cnt <= done_cnt + 1;
      if (valid_v[0] && in_frame) proto_err <= proto_err + 1;
      if (!in_frame) begin
        if (!tx_v[0]) begin
          in_frame <= 1'b1;
          mcnt     <= 1;
          starts.push_back(cyc);
        end
      end else begin
        mcnt <= mcnt + 1;
        if (mcnt % 4 == 2 && mcnt >= 6 && mcnt <= 34) rx_sh <= {tx_v[0], rx_sh[7:1]};
        if (mcnt == 38) begin
          in_frame <= 1'b0;
          rx_q.push_back(rx_sh);
          if (!tx_v[0]) stop_err <= stop_err + 1;
        end
      end
    end
  end
  task automatic restart_monitor();
    @(negedge clk); #1 mon_en = 1'b0;
    @(negedge clk); #1 mon_en = 1'b1;
  endtask
  task automatic pulse(input int sel, input logic [7:0] b);
    @(negedge clk); #1 byte_in = b; valid_v[sel] = 1'b1;
    @(negedge clk); #1 valid_v[sel] = 1'b0;
  endtask
  // sends one byte and samples every cycle of the frame: seq[i] is frame bit i
  task automatic run_frame(input int sel, input logic [7:0] b, input int nbits,
                           output logic [11:0] seq, output int done_at, output int done_n,
                           output int bad, output logic busy_acc);
    seq = '0; done_at = 0; done_n = 0; bad = 0;
    @(negedge clk); #1 byte_in = b; valid_v[sel] = 1'b1;
    #1 busy_acc = busy_v[sel];
    @(negedge clk); #1 valid_v[sel] = 1'b0;
    for (int n = 1; n <= nbits * 4 + 2; n++) begin
      int idx;
      idx = (n - 1) / 4;
      if (idx < nbits) begin
        if ((n - 1) % 4 == 0) seq[idx] = tx_v[sel];
        else if (tx_v[sel] !== seq[idx]) bad++;
      end else if (tx_v[sel] !== 1'b1) bad++;
      if (busy_v[sel] !== (n <= nbits * 4)) bad++;
      if (done_v[sel]) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
      if (n < nbits * 4 + 2) @(negedge clk);
    end
  endtask
  task automatic test_reset();
    int errs;
    errs = 0;
    #1 rst_n = 1'b0;
    #10;
    tests++;
    if ({tx_v, busy_v, done_v} !== 9'b111_000_000) begin
      fails++;
      $display("FAIL reset_outputs: tx/busy/done=%b required 111000000", {tx_v, busy_v, done_v});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_v !== 3'b111 || done_v !== 3'b000 || busy_v !== 3'b000) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL reset_idle_line: %0d bad idle cycles, required 0", errs);
    end
  endtask
  task automatic test_single();
    logic [11:0] seq;
    int done_at, done_n, bad;
    logic busy_acc;
    run_frame(0, 8'hA5, 10, seq, done_at, done_n, bad, busy_acc);
    tests++;
    if (seq[9:0] !== 10'b1_1010_0101_0) begin
      fails++;
      $display("FAIL single_bits: got %b required %b", seq[9:0], 10'b1_1010_0101_0);
    end
    tests++;
    if (done_at != 41 || done_n != 1) begin
      fails++;
      $display("FAIL single_done: at %0d count %0d, required at 41 count 1", done_at, done_n);
    end
    tests++;
    if (bad != 0 || busy_acc !== 1'b1) begin
      fails++;
      $display("FAIL single_timing_busy: bad=%0d busy_on_valid=%b, required 0 and 1", bad, busy_acc);
    end
  endtask
  task automatic test_parity();
    logic [11:0] seq;
    int done_at, done_n, bad;
    logic busy_acc;
    run_frame(1, 8'h07, 12, seq, done_at, done_n, bad, busy_acc);
    tests++;
    if (seq !== 12'b11_1_0000_0111_0) begin
      fails++;
      $display("FAIL parity_even_bits: got %b required %b", seq, 12'b11_1_0000_0111_0);
    end
    tests++;
    if (done_at != 49 || done_n != 1 || bad != 0) begin
      fails++;
      $display("FAIL parity_even_frame: done_at %0d count %0d bad %0d, required 49 1 0", done_at, done_n, bad);
    end
    run_frame(2, 8'h07, 12, seq, done_at, done_n, bad, busy_acc);
    tests++;
    if (seq !== 12'b11_0_0000_0111_0) begin
      fails++;
      $display("FAIL parity_odd_bits: got %b required %b", seq, 12'b11_0_0000_0111_0);
    end
    tests++;
    if (done_at != 49 || done_n != 1 || bad != 0) begin
      fails++;
      $display("FAIL parity_odd_frame: done_at %0d count %0d bad %0d, required 49 1 0", done_at, done_n, bad);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int max_gap, min_gap;
    restart_monitor();
    for (int i = 0; i < 8; i++) begin
      int t;
      t = 0;
      while (busy_v[0] && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (busy_v[0]) begin
        tests++;
        fails++;
        $display("FAIL b2b_timeout: byte %0d still busy after %0d cycles", i, t);
      end
      #1 byte_in = exp[i]; valid_v[0] = 1'b1;
      @(negedge clk); #1 valid_v[0] = 1'b0;
    end
    repeat (50) @(negedge clk);
    tests++;
    if (rx_q.size() != 8) begin
      fails++;
      $display("FAIL b2b_count: received %0d bytes, required 8", rx_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
      end
    end
    tests++;
    if (done_cnt != 8 || stop_err != 0) begin
      fails++;
      $display("FAIL b2b_done: %0d pulses %0d stop errors, required 8 and 0", done_cnt, stop_err);
    end
    max_gap = 0;
    min_gap = 1000;
    for (int i = 1; i < starts.size(); i++) begin
      if (starts[i] - starts[i-1] > max_gap) max_gap = starts[i] - starts[i-1];
      if (starts[i] - starts[i-1] < min_gap) min_gap = starts[i] - starts[i-1];
    end
    tests++;
    if (starts.size() != 8 || max_gap > 42 || min_gap < 40) begin
      fails++;
      $display("FAIL b2b_spacing: %0d starts spacing %0d..%0d, required 8 starts within 40..42", starts.size(), min_gap, max_gap);
    end
  endtask
  task automatic test_ignore_mid();
    restart_monitor();
    pulse(0, 8'h00);
    repeat (15) @(negedge clk);
    pulse(0, 8'hFF);
    repeat (40) @(negedge clk);
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h00) begin
      fails++;
      $display("FAIL ignore_frame: %0d bytes first %h, required 1 byte 00", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    tests++;
    if (done_cnt != 1 || proto_err != 1 || stop_err != 0) begin
      fails++;
      $display("FAIL ignore_counts: done %0d proto %0d stop_err %0d, required 1 1 0", done_cnt, proto_err, stop_err);
    end
  endtask
  task automatic test_reset_mid();
    logic [11:0] seq;
    int done_at, done_n, bad;
    logic busy_acc;
    logic busy_before;
    pulse(0, 8'h3C);
    repeat (17) @(negedge clk);
    busy_before = busy_v[0];
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (busy_before !== 1'b1 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_abort: busy_before %b tx %b busy %b, required 1 1 0", busy_before, tx_v[0], busy_v[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    run_frame(0, 8'h3C, 10, seq, done_at, done_n, bad, busy_acc);
    tests++;
    if (seq[9:0] !== 10'b1_0011_1100_0 || done_at != 41 || done_n != 1 || bad != 0) begin
      fails++;
      $display("FAIL reset_mid_resend: bits %b done_at %0d count %0d bad %0d, required %b 41 1 0",
               seq[9:0], done_at, done_n, bad, 10'b1_0011_1100_0);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_ignore_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
